manchester_rx_deframer: RTL and testbench

Serial Manchester receiver that sits directly upstream of the Manchester encode/decode core. Oversamples a single-wire line, detects the start violation, recovers 16 chips per frame and presents them as a 16-bit chip word plus the decoded byte. Flags Manchester code errors and framing errors per frame. The chip word feeds the core's decode path unchanged.

---
 rtl/manchester_rx_deframer.sv | 159 +++++++++++++++
 tb/tb_manchester_rx_deframer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/manchester_rx_deframer.sv
// Manchester receiver: oversampled start-violation framing, 16 chips per frame.
// Define MANCH_RX_GLITCH_FILTER_EN to add a 3-sample majority filter on the line.
module manchester_rx_deframer #(
   parameter int OVERSAMPLE = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rx_in,
   input  logic        enable,
   output logic [15:0] chip_word,
   output logic [7:0]  data_out,
   output logic        data_valid,
   output logic        code_err,
   output logic        frame_err,
   output logic        busy
);
   localparam int PW = $clog2(OVERSAMPLE);
   localparam logic [PW-1:0] PH_LAST = PW'(OVERSAMPLE - 1);
   localparam logic [PW-1:0] PH_SAMP = PW'(OVERSAMPLE / 2);
   localparam logic [PW-1:0] PH_ONE  = PW'(1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state, state_nxt;
   logic          sync1, sync2, rx_s, rx_d;
   logic [PW-1:0] phase, phase_nxt;
   logic [3:0]    cnt, cnt_nxt;
   logic [15:0]   shreg, shreg_nxt;
   logic          done, sample, start_edge;
   logic          cerr;
   logic [7:0]    dec;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         rx_d  <= 1'b0;
      end else begin
         sync1 <= rx_in;
         sync2 <= sync1;
         rx_d  <= rx_s;
      end
   end

`ifdef MANCH_RX_GLITCH_FILTER_EN
   logic [1:0] hist;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) hist <= '0;
      else        hist <= {hist[0], sync2};
   end

   assign rx_s = (sync2 & hist[0]) | (sync2 & hist[1]) | (hist[0] & hist[1]);
`else
   assign rx_s = sync2;
`endif

   assign start_edge = rx_s & ~rx_d & enable;
   assign sample     = (phase == PH_SAMP);
   assign busy       = (state != IDLE);

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      shreg_nxt = shreg;
      done      = 1'b0;
      phase_nxt = '0;
      if (state != IDLE)
         phase_nxt = (phase == PH_LAST) ? '0 : phase + PH_ONE;
      unique case (state)
         IDLE: begin
            // the edge cycle itself counts as phase 0
            if (start_edge) begin
               state_nxt = START;
               phase_nxt = PH_ONE;
               cnt_nxt   = '0;
            end
         end
         START: begin
            if (sample) begin
               if (!rx_s)
                  state_nxt = IDLE;
               else if (cnt == 4'd1) begin
                  state_nxt = DATA;
                  cnt_nxt   = '0;
               end else
                  cnt_nxt = cnt + 4'd1;
            end
         end
         DATA: begin
            if (sample) begin
               shreg_nxt = {shreg[14:0], rx_s};
               cnt_nxt   = cnt + 4'd1;
               if (cnt == 4'd15) state_nxt = STOP;
            end
         end
         STOP: begin
            if (sample) begin
               state_nxt = IDLE;
               done      = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (!enable) begin
         state_nxt = IDLE;
         done      = 1'b0;
      end
      if (state_nxt == IDLE) begin
         phase_nxt = '0;
         cnt_nxt   = '0;
         shreg_nxt = '0;
      end
   end

   always_comb begin
      cerr = 1'b0;
      dec  = '0;
      for (int i = 0; i < 8; i++) begin
         cerr   = cerr | (shreg[2*i+1] == shreg[2*i]);
         dec[i] = shreg[2*i+1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         phase <= '0;
         cnt   <= '0;
         shreg <= '0;
      end else begin
         state <= state_nxt;
         phase <= phase_nxt;
         cnt   <= cnt_nxt;
         shreg <= shreg_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chip_word  <= '0;
         data_out   <= '0;
         data_valid <= 1'b0;
         code_err   <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         data_valid <= 1'b0;
         code_err   <= 1'b0;
         frame_err  <= 1'b0;
         if (done) begin
            chip_word  <= shreg;
            code_err   <= cerr;
            frame_err  <= rx_s;
            data_valid <= ~cerr & ~rx_s;
            if (!cerr && !rx_s) data_out <= dec;
         end
      end
   end
endmodule

// File: tb/tb_manchester_rx_deframer.sv
// Scoreboard bench for manchester_rx_deframer at OVERSAMPLE = 4.
// Expected frames are queued when driven and matched against completion pulses.
`timescale 1ns/1ps
module tb_manchester_rx_deframer;
   localparam int OS = 4;
`ifdef MANCH_RX_GLITCH_FILTER_EN
   localparam int FILT = 1;
`else
   localparam int FILT = 0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rx_in = 1'b0;
   logic        enable = 1'b0;
   logic [15:0] chip_word;
   logic [7:0]  data_out;
   logic        data_valid, code_err, frame_err, busy;

   int unsigned cyc = 0;
   int          checks = 0;
   int          errors = 0;

   typedef struct {
      int unsigned cyc;
      logic [15:0] cw;
      logic [7:0]  d;
      logic        dv, ce, fe;
   } exp_t;

   exp_t       sb[$];
   exp_t       got_e;
   logic [7:0] model_d = 8'h00;

   manchester_rx_deframer #(.OVERSAMPLE(OS)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx_in      (rx_in),
      .enable     (enable),
      .chip_word  (chip_word),
      .data_out   (data_out),
      .data_valid (data_valid),
      .code_err   (code_err),
      .frame_err  (frame_err),
      .busy       (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] enc(input logic [7:0] b);
      logic [15:0] c;
      for (int i = 0; i < 8; i++) begin
         c[2*i+1] = b[i];
         c[2*i]   = ~b[i];
      end
      return c;
   endfunction

   task automatic expect_frame(input logic [15:0] c, input logic stop,
                               input int unsigned t0);
      exp_t       e;
      logic       ce;
      logic [7:0] d;
      ce = 1'b0;
      for (int i = 0; i < 8; i++) begin
         ce   = ce | (c[2*i+1] == c[2*i]);
         d[i] = c[2*i+1];
      end
      e.cyc = t0 + 2 + FILT + 18*OS + OS/2 + 1;
      e.cw  = c;
      e.ce  = ce;
      e.fe  = stop;
      e.dv  = !ce && !stop;
      if (e.dv) model_d = d;
      e.d = model_d;
      sb.push_back(e);
   endtask

   task automatic idle(input int n);
      @(posedge clk); #1;
      rx_in = 1'b0;
      repeat (n) @(posedge clk);
   endtask

   task automatic drive_frame(input logic [15:0] c, input logic stop,
                              input int cut_k, input bit cut_rst,
                              input bit push);
      logic [18:0] h;
      h = {2'b11, c, stop};
      for (int k = 0; k < 19; k++) begin
         @(posedge clk); #1;
         if (k == 0 && push) expect_frame(c, stop, cyc);
         if (k == cut_k) begin
            if (cut_rst) begin
               rst_n = 1'b0;
               #1;
               check("rst_chip_word", chip_word, 16'h0);
               check("rst_data_out", data_out, 8'h0);
               check("rst_busy", busy, 1'b0);
               check("rst_pulses", {data_valid, code_err, frame_err}, 3'b0);
               rx_in   = 1'b0;
               model_d = 8'h00;
               repeat (3) @(posedge clk);
               @(negedge clk);
               rst_n = 1'b1;
            end else begin
               check("busy_pre_abort", busy, 1'b1);
               enable = 1'b0;
               rx_in  = 1'b0;
               @(posedge clk);
               @(negedge clk);
               check("busy_post_abort", busy, 1'b0);
            end
            return;
         end
         rx_in = h[18-k];
         repeat (OS-1) @(posedge clk);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && (data_valid || code_err || frame_err)) begin
         if (sb.size() == 0) begin
            check("unexpected_pulse", {data_valid, code_err, frame_err}, 3'b0);
         end else begin
            got_e = sb.pop_front();
            check("pulse_cycle", cyc, got_e.cyc);
            check("chip_word", chip_word, got_e.cw);
            check("data_out", data_out, got_e.d);
            check("data_valid", data_valid, got_e.dv);
            check("code_err", code_err, got_e.ce);
            check("frame_err", frame_err, got_e.fe);
         end
      end
   end

   initial begin
      int unsigned tg;
      int          nb;
      logic [15:0] c;

      repeat (3) @(posedge clk);
      #1;
      check("reset_chip_word", chip_word, 16'h0);
      check("reset_data_out", data_out, 8'h0);
      check("reset_pulses", {data_valid, code_err, frame_err}, 3'b0);
      check("reset_busy", busy, 1'b0);
      @(negedge clk);
      rst_n  = 1'b1;
      enable = 1'b1;
      idle(8);

      drive_frame(enc(8'hA5), 1'b0, -1, 1'b0, 1'b1);
      idle(10);

      @(posedge clk); #1;
      rx_in = 1'b1;
      tg    = cyc;
      @(posedge clk); #1;
      rx_in = 1'b0;
      nb    = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (busy) nb++;
         if (cyc == tg + 2 + FILT + 3) check("glitch_busy_e3", busy, 1'b0);
      end
      check("glitch_busy_cycles", nb, (FILT != 0) ? 0 : 2);
      idle(4);

      c = enc(8'h3C);
      c[7:6] = 2'b11;
      drive_frame(c, 1'b0, -1, 1'b0, 1'b1);
      idle(10);

      drive_frame(enc(8'hFF), 1'b1, -1, 1'b0, 1'b1);
      idle(10);

      drive_frame(enc(8'h01), 1'b0, -1, 1'b0, 1'b1);
      drive_frame(enc(8'h80), 1'b0, -1, 1'b0, 1'b1);
      idle(10);

      drive_frame(enc(8'h55), 1'b0, 9, 1'b0, 1'b0);
      idle(OS*20);
      check("abort_chip_word", chip_word, 16'h9555);
      check("abort_data_out", data_out, 8'h80);
      @(posedge clk); #1;
      enable = 1'b1;
      idle(5);

      drive_frame(enc(8'hC3), 1'b0, 10, 1'b1, 1'b0);
      idle(8);
      drive_frame(enc(8'h5A), 1'b0, -1, 1'b0, 1'b1);
      idle(10);

      for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
      check("sb_drained", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
